core_mem_arb: RTL and testbench

- Parametrised N-channel request arbiter: merges the core's instruction, data and any future requester channels onto one memory request port.
- Generalises the fixed two-channel core hookup to NUM_CH channels.
- Adds selectable fixed-priority or round-robin arbitration, per-channel ack routing and a request timeout with error reporting.
- Sits between the core request ports and the memory/fabric model or bus.

---
 rtl/core_mem_arb_if.sv | 43 ++++
 rtl/core_mem_arb.sv | 156 +++++++++++++++
 tb/tb_core_mem_arb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arb_if.sv
// Bundle of request/ack signals between requesters, the arbiter and memory.
// No logic or latency; widths follow the arbiter parameters.
// The master side drives requests and memory acks; the slave side is the arbiter.
interface core_mem_arb_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int COP_W  = 3,
  parameter int SIZE_W = 3
);
  localparam int GID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        ch_req_val;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
  logic [NUM_CH*COP_W-1:0]  ch_req_cop;
  logic [NUM_CH*DATA_W-1:0] ch_req_wdata;
  logic [NUM_CH*SIZE_W-1:0] ch_req_size;
  logic [NUM_CH-1:0]        ch_req_ack;
  logic [DATA_W-1:0]        ch_ack_rdata;
  logic                     ch_ack_err;
  logic                     m_req_val;
  logic [ADDR_W-1:0]        m_req_addr;
  logic [COP_W-1:0]         m_req_cop;
  logic [DATA_W-1:0]        m_req_wdata;
  logic [SIZE_W-1:0]        m_req_size;
  logic                     m_req_ack;
  logic [DATA_W-1:0]        m_ack_rdata;
  logic [GID_W-1:0]         grant_id;

  modport master (
    output ch_req_val, ch_req_addr, ch_req_cop, ch_req_wdata, ch_req_size,
    output m_req_ack, m_ack_rdata,
    input  ch_req_ack, ch_ack_rdata, ch_ack_err,
    input  m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size, grant_id
  );

  modport slave (
    input  ch_req_val, ch_req_addr, ch_req_cop, ch_req_wdata, ch_req_size,
    input  m_req_ack, m_ack_rdata,
    output ch_req_ack, ch_ack_rdata, ch_ack_err,
    output m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size, grant_id
  );
endinterface

// File: rtl/core_mem_arb.sv
// N-channel request arbiter (fixed priority or round robin) onto one memory port.
// Latency: request valid -> m_req_val 1 cycle; memory ack -> channel ack 1 cycle.
// Backpressure: requests held until acked; one transaction in flight, optional timeout.
module core_mem_arb #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int COP_W       = 3,
  parameter int SIZE_W      = 3,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 256
) (
  input logic           clk,
  input logic           rst,
  core_mem_arb_if.slave bus
);
  localparam int GID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [GID_W-1:0]  r_ptr;
  logic [GID_W-1:0]  r_gid;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_m_val;
  logic [ADDR_W-1:0] r_addr;
  logic [COP_W-1:0]  r_cop;
  logic [DATA_W-1:0] r_wdata;
  logic [SIZE_W-1:0] r_size;
  logic [NUM_CH-1:0] r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [GID_W-1:0]  w_base;
  logic [NUM_CH-1:0] w_rot;
  logic [GID_W:0]    w_sum;
  logic [GID_W-1:0]  w_win;
  logic [GID_W-1:0]  w_ptr_nxt;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [COP_W-1:0]  w_cop;
  logic [DATA_W-1:0] w_wdata;
  logic [SIZE_W-1:0] w_size;
  logic [NUM_CH-1:0] w_oh;

  // Winner: rotate the request vector so the search start sits at bit 0, take the
  // lowest set bit, then map back. Fixed priority is the same search from 0.
  always_comb begin
    w_base = (ARB_MODE != 0) ? r_ptr : '0;
    w_rot  = NUM_CH'({bus.ch_req_val, bus.ch_req_val} >> w_base);
    w_any  = |w_rot;
    w_sum  = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (w_rot[j]) w_sum = (GID_W+1)'(j);
    end
    w_sum = w_sum + {1'b0, w_base};
    if (w_sum >= (GID_W+1)'(NUM_CH)) w_sum = w_sum - (GID_W+1)'(NUM_CH);
    w_win     = w_sum[GID_W-1:0];
    w_ptr_nxt = (w_win == GID_W'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
  end

  // Pick the winning channel's request fields out of the flattened buses.
  always_comb begin
    w_addr  = '0;
    w_cop   = '0;
    w_wdata = '0;
    w_size  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_win == GID_W'(c)) begin
        w_addr  = bus.ch_req_addr[c*ADDR_W +: ADDR_W];
        w_cop   = bus.ch_req_cop[c*COP_W +: COP_W];
        w_wdata = bus.ch_req_wdata[c*DATA_W +: DATA_W];
        w_size  = bus.ch_req_size[c*SIZE_W +: SIZE_W];
      end
    end
    w_oh = NUM_CH'(1) << r_gid;
  end

  // IDLE/BUSY/RESP sequencing; reset drops any in-flight request without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_m_val <= 1'b0;
      r_addr  <= '0;
      r_cop   <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= '0;
          if (w_any) begin
            r_m_val <= 1'b1;
            r_addr  <= w_addr;
            r_cop   <= w_cop;
            r_wdata <= w_wdata;
            r_size  <= w_size;
            r_gid   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.m_req_ack) begin
            r_rdata <= bus.m_ack_rdata;
            r_err   <= 1'b0;
            r_m_val <= 1'b0;
            r_ack   <= w_oh;
            r_state <= S_RESP;
          end else if (TO_EN) begin
            if (r_cnt == CNT_LAST) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_m_val <= 1'b0;
              r_ack   <= w_oh;
              r_state <= S_RESP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RESP: begin
          r_ack   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack   <= '0;
          r_m_val <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.m_req_val    = r_m_val;
  assign bus.m_req_addr   = r_addr;
  assign bus.m_req_cop    = r_cop;
  assign bus.m_req_wdata  = r_wdata;
  assign bus.m_req_size   = r_size;
  assign bus.ch_req_ack   = r_ack;
  assign bus.ch_ack_rdata = r_rdata;
  assign bus.ch_ack_err   = r_err;
  assign bus.grant_id     = r_gid;
endmodule

// File: tb/tb_core_mem_arb.sv
// Bench for core_mem_arb: a 2-channel fixed-priority instance with an 8-cycle
// timeout and a 4-channel round-robin instance without timeout, driven by
// directed steps with random payloads against a transaction-level model.
module tb_core_mem_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_mem_arb_if #(.NUM_CH(2)) ifa ();
  core_mem_arb_if #(.NUM_CH(4)) ifb ();

  core_mem_arb #(.NUM_CH(2), .ARB_MODE(0), .TIMEOUT_CYC(8)) u_fp (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  core_mem_arb #(.NUM_CH(4), .ARB_MODE(1), .TIMEOUT_CYC(0)) u_rr (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  // stimulus storage, index 0 = fixed-priority instance, 1 = round-robin instance
  logic [3:0]  val  [2];
  logic [31:0] addr [2][4];
  logic [31:0] wdat [2][4];
  logic [2:0]  cop  [2][4];
  logic [2:0]  siz  [2][4];
  logic        mack [2];
  logic [31:0] mrd  [2];

  assign ifa.ch_req_val   = val[0][1:0];
  assign ifa.ch_req_addr  = {addr[0][1], addr[0][0]};
  assign ifa.ch_req_wdata = {wdat[0][1], wdat[0][0]};
  assign ifa.ch_req_cop   = {cop[0][1], cop[0][0]};
  assign ifa.ch_req_size  = {siz[0][1], siz[0][0]};
  assign ifa.m_req_ack    = mack[0];
  assign ifa.m_ack_rdata  = mrd[0];
  assign ifb.ch_req_val   = val[1];
  assign ifb.ch_req_addr  = {addr[1][3], addr[1][2], addr[1][1], addr[1][0]};
  assign ifb.ch_req_wdata = {wdat[1][3], wdat[1][2], wdat[1][1], wdat[1][0]};
  assign ifb.ch_req_cop   = {cop[1][3], cop[1][2], cop[1][1], cop[1][0]};
  assign ifb.ch_req_size  = {siz[1][3], siz[1][2], siz[1][1], siz[1][0]};
  assign ifb.m_req_ack    = mack[1];
  assign ifb.m_ack_rdata  = mrd[1];

  // reference model configuration and state
  int  nch  [2] = '{2, 4};
  int  mode [2] = '{0, 1};
  int  tmo  [2] = '{8, 0};
  int  ptr  [2];
  int  obs_cnt [2][4];
  int  total = 0;
  int  bad = 0;
  int  last_gid;
  bit  ack_always = 1'b0;
  time resp_t;

  function automatic logic [31:0] o_mval(int s);  return s != 0 ? 32'(ifb.m_req_val)    : 32'(ifa.m_req_val);    endfunction
  function automatic logic [31:0] o_gid(int s);   return s != 0 ? 32'(ifb.grant_id)     : 32'(ifa.grant_id);     endfunction
  function automatic logic [31:0] o_addr(int s);  return s != 0 ? ifb.m_req_addr        : ifa.m_req_addr;        endfunction
  function automatic logic [31:0] o_wdat(int s);  return s != 0 ? ifb.m_req_wdata       : ifa.m_req_wdata;       endfunction
  function automatic logic [31:0] o_cop(int s);   return s != 0 ? 32'(ifb.m_req_cop)    : 32'(ifa.m_req_cop);    endfunction
  function automatic logic [31:0] o_size(int s);  return s != 0 ? 32'(ifb.m_req_size)   : 32'(ifa.m_req_size);   endfunction
  function automatic logic [31:0] o_ack(int s);   return s != 0 ? 32'(ifb.ch_req_ack)   : 32'(ifa.ch_req_ack);   endfunction
  function automatic logic [31:0] o_rdata(int s); return s != 0 ? ifb.ch_ack_rdata      : ifa.ch_ack_rdata;      endfunction
  function automatic logic [31:0] o_err(int s);   return s != 0 ? 32'(ifb.ch_ack_err)   : 32'(ifa.ch_ack_err);   endfunction

  // expected winner from the arbitration rules: search upward from the start
  // point (0 for fixed priority, the pointer for round robin), wrapping
  function automatic int pick(int s, logic [3:0] v);
    for (int k = 0; k < nch[s]; k++) begin
      int c;
      c = (mode[s] == 1) ? (ptr[s] + k) % nch[s] : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input int c);
    val[s][c]  = 1'b1;
    addr[s][c] = $urandom;
    wdat[s][c] = $urandom;
    cop[s][c]  = 3'($urandom);
    siz[s][c]  = 3'($urandom_range(1, 4));
  endtask

  task automatic check_all_zero(input int s);
    chk("rst_mval", o_mval(s), 0);
    chk("rst_addr", o_addr(s), 0);
    chk("rst_wdat", o_wdat(s), 0);
    chk("rst_cop", o_cop(s), 0);
    chk("rst_size", o_size(s), 0);
    chk("rst_gid", o_gid(s), 0);
    chk("rst_ack", o_ack(s), 0);
    chk("rst_rdata", o_rdata(s), 0);
    chk("rst_err", o_err(s), 0);
  endtask

  // One transaction: called in an IDLE cycle with requests presented; lat is the
  // number of BUSY cycles before the memory ack (negative = never). Returns in
  // the IDLE cycle after the response with the granted channel's request dropped.
  task automatic txn(input int s, input int lat, input logic [31:0] rd, output int w);
    logic [31:0] ea, ew, erd, av;
    logic [2:0]  ec, ez;
    logic        eerr;
    bit          done;
    w = pick(s, val[s]);
    if (mode[s] == 1) ptr[s] = (w + 1) % nch[s];
    ea = addr[s][w]; ew = wdat[s][w]; ec = cop[s][w]; ez = siz[s][w];
    erd = '0; eerr = 1'b0;
    step();
    last_gid = int'(o_gid(s));
    chk("grant_val", o_mval(s), 1);
    chk("grant_id", o_gid(s), w);
    chk("grant_addr", o_addr(s), ea);
    chk("grant_wdat", o_wdat(s), ew);
    chk("grant_cop", o_cop(s), 32'(ec));
    chk("grant_size", o_size(s), 32'(ez));
    chk("grant_noack", o_ack(s), 0);
    // the requester changes its fields while waiting; the memory side must not see it
    addr[s][w] = ~ea;
    wdat[s][w] = $urandom;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (lat >= 0 && n == lat) begin
        mack[s] = 1'b1; mrd[s] = rd; erd = rd; eerr = 1'b0; done = 1'b1;
      end else if (tmo[s] != 0 && n == tmo[s] - 1) begin
        erd = '0; eerr = 1'b1; done = 1'b1;
      end
      step();
      if (!done) begin
        chk("busy_val", o_mval(s), 1);
        chk("busy_addr", o_addr(s), ea);
      end
    end
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL txn_bound observed=no_completion expected=completion");
    end
    if (!ack_always) mack[s] = 1'b0;
    resp_t = $time;
    av = o_ack(s);
    for (int c = 0; c < 4; c++) if (av[c]) obs_cnt[s][c]++;
    chk("resp_ack", av, 32'(1) << w);
    chk("resp_rdata", o_rdata(s), erd);
    chk("resp_err", o_err(s), 32'(eerr));
    chk("resp_mval", o_mval(s), 0);
    val[s][w] = 1'b0;
    step();
    chk("idle_noack", o_ack(s), 0);
    chk("idle_mval", o_mval(s), 0);
  endtask

  initial begin
    int w;
    time t_prev;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      val[s] = '0; mack[s] = 1'b0; mrd[s] = '0; ptr[s] = 0;
      for (int c = 0; c < 4; c++) begin
        addr[s][c] = '0; wdat[s][c] = '0; cop[s][c] = '0; siz[s][c] = '0; obs_cnt[s][c] = 0;
      end
    end
    repeat (3) step();
    check_all_zero(0);
    check_all_zero(1);
    rst = 1'b0;
    step();
    chk("idle_quiet_a", o_mval(0), 0);
    chk("idle_quiet_b", o_mval(1), 0);

    // single request on channel 1
    set_req(0, 1);
    addr[0][1] = 32'h0000_1000; cop[0][1] = 3'b001; wdat[0][1] = 32'hA5A5_A5A5; siz[0][1] = 3'd4;
    txn(0, 0, 32'h1234_5678, w);

    // fixed priority contention: ch0 wins while it keeps requesting
    set_req(0, 0);
    set_req(0, 1);
    for (int i = 0; i < 4; i++) begin
      txn(0, $urandom_range(0, 3), $urandom, w);
      chk("fp_ch0_wins", last_gid, 0);
      set_req(0, w);
    end
    val[0][0] = 1'b0;
    txn(0, 1, $urandom, w);
    chk("fp_ch1_after_drop", last_gid, 1);

    // timeout with no memory ack, then a late ack that must be ignored
    set_req(0, 0);
    txn(0, -1, 32'h0, w);
    step();
    mack[0] = 1'b1; mrd[0] = $urandom;
    step();
    mack[0] = 1'b0;
    chk("late_ack_ignored", o_ack(0), 0);
    step();
    chk("late_ack_quiet", o_ack(0), 0);
    chk("late_ack_mval", o_mval(0), 0);

    // asynchronous reset while BUSY, then normal re-arbitration
    set_req(0, 1);
    step();
    chk("pre_rst_busy", o_mval(0), 1);
    #2 rst = 1'b1;
    #1 check_all_zero(0);
    step();
    chk("rst_hold_noack", o_ack(0), 0);
    rst = 1'b0;
    ptr[0] = 0; ptr[1] = 0;
    txn(0, 2, $urandom, w);
    chk("post_rst_grant", last_gid, 1);

    // back-to-back with memory ack stuck high: one completion every 3 cycles
    ack_always = 1'b1;
    mack[0] = 1'b1;
    set_req(0, 0);
    txn(0, 0, $urandom, w);
    for (int i = 0; i < 4; i++) begin
      t_prev = resp_t;
      set_req(0, 0);
      txn(0, 0, $urandom, w);
      chk("b2b_period", 32'(resp_t - t_prev), 30);
    end
    ack_always = 1'b0;
    mack[0] = 1'b0;
    step();

    // round robin with all four channels requesting continuously
    for (int c = 0; c < 4; c++) set_req(1, c);
    for (int i = 0; i < 5; i++) begin
      txn(1, $urandom_range(0, 2), $urandom, w);
      chk("rr_order", last_gid, i % 4);
      if (i == 3) for (int c = 0; c < 4; c++) chk("rr_once_each", obs_cnt[1][c], 1);
      set_req(1, w);
    end

    // timeout disabled: a long memory latency still completes without error
    txn(1, 20, $urandom, w);
    set_req(1, w);

    // random request patterns, one instance at a time
    for (int s = 0; s < 2; s++) begin
      if (val[s] == 0) set_req(s, $urandom_range(0, nch[s] - 1));
      for (int it = 0; it < 15; it++) begin
        int lat;
        lat = (s == 0 && $urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 4);
        txn(s, lat, $urandom, w);
        for (int c = 0; c < nch[s]; c++)
          if (!val[s][c] && $urandom_range(0, 1) == 1) set_req(s, c);
        if (val[s] == 0) set_req(s, $urandom_range(0, nch[s] - 1));
      end
      val[s] = '0;
      step();
      chk("rand_drain", o_mval(s), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
